// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter must be at least one bit wide even when a single digit covers the word.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit for overflow.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic c;

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred,
        // and blocking assignments let the ripple carry propagate within one evaluation.
        s        = '0;
        c_msb_in = 1'b0;
        c        = cin;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb_in = c;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: load captures operands, start runs NDIG digit steps, done holds the result.
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int NDIG  = ndig(WIDTH, DIGIT);
    localparam int CNT_W = cnt_width(NDIG);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q, res_d, sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q, carry_out_q, overflow_q, busy_q, done_q;

    logic [DIGIT-1:0]   dig_s;
    logic               dig_cout, dig_cmsb;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a        (a_q[DIGIT-1:0]),
        .b        (b_q[DIGIT-1:0]),
        .cin      (carry_q),
        .s        (dig_s),
        .cout     (dig_cout),
        .c_msb_in (dig_cmsb)
    );

    // Each new digit enters at the MSB end, so after NDIG steps the word is in place.
    assign res_d = (res_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, LOADED, DONE: begin
                    if (load) begin
                        // Subtraction is A + ~B + 1; the carry register holds the mode as the +1.
                        a_q     <= A;
                        b_q     <= (mode == MODE_SUB) ? ~B : B;
                        carry_q <= mode;
                        done_q  <= 1'b0;
                        state_q <= LOADED;
                    end else if (state_q == LOADED && start) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= dig_cout;
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NDIG - 1)) begin
                        sum_q       <= res_d;
                        carry_out_q <= dig_cout;
                        overflow_q  <= dig_cmsb ^ dig_cout;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 4-bit/1-bit-digit and 8-bit/2-bit-digit instances.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-bit, one bit per cycle
    logic       load4 = 0, start4 = 0, mode4 = 0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       c4, v4, busy4, done4;

    // 8-bit, two bits per cycle
    logic       load8 = 0, start8 = 0, mode8 = 0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       c8, v8, busy8, done8;

    serial_addsub #(.WIDTH(4), .DIGIT(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load4), .start(start4), .mode(mode4),
        .A(a4), .B(b4), .sum(sum4), .carry_out(c4), .overflow(v4),
        .busy(busy4), .done(done4)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .load(load8), .start(start8), .mode(mode8),
        .A(a8), .B(b8), .sum(sum8), .carry_out(c8), .overflow(v8),
        .busy(busy8), .done(done8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        logic [3:0] s;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[9];

    // Load, pulse start, then measure latency and busy length; all sampling on negedges.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic m,
                        input logic [3:0] es, input logic ec, input logic ev, input string tag);
        int edges = 0;
        int busy_cnt = 0;
        @(negedge clk);
        load4 = 1; a4 = a; b4 = b; mode4 = m;
        @(negedge clk);
        load4 = 0; start4 = 1;
        check({tag, " done low after load"}, done4, 0);
        @(negedge clk);
        start4 = 0;
        while (!done4 && edges < 20) begin
            if (busy4) busy_cnt++;
            @(negedge clk);
            edges++;
        end
        check({tag, " latency"}, edges, 4);
        check({tag, " busy cycles"}, busy_cnt, 4);
        check({tag, " sum"}, sum4, es);
        check({tag, " carry_out"}, c4, ec);
        check({tag, " overflow"}, v4, ev);
        check({tag, " busy after done"}, busy4, 0);
    endtask

    initial begin
        vecs[0] = '{a: 4'd4,  b: 4'd5,  m: 1'b0, s: 4'd9,  c: 1'b0, v: 1'b1};
        vecs[1] = '{a: 4'd12, b: 4'd11, m: 1'b0, s: 4'd7,  c: 1'b1, v: 1'b1};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  m: 1'b0, s: 4'd0,  c: 1'b0, v: 1'b0};
        vecs[3] = '{a: 4'd3,  b: 4'd5,  m: 1'b1, s: 4'd14, c: 1'b0, v: 1'b0};
        vecs[4] = '{a: 4'd5,  b: 4'd3,  m: 1'b1, s: 4'd2,  c: 1'b1, v: 1'b0};
        vecs[5] = '{a: 4'd5,  b: 4'd0,  m: 1'b1, s: 4'd5,  c: 1'b1, v: 1'b0};
        vecs[6] = '{a: 4'd0,  b: 4'd1,  m: 1'b1, s: 4'd15, c: 1'b0, v: 1'b0};
        vecs[7] = '{a: 4'd7,  b: 4'd1,  m: 1'b0, s: 4'd8,  c: 1'b0, v: 1'b1};
        vecs[8] = '{a: 4'd8,  b: 4'd1,  m: 1'b1, s: 4'd7,  c: 1'b1, v: 1'b1};

        // Reset state
        #12;
        check("reset sum4", sum4, 0);
        check("reset carry4", c4, 0);
        check("reset ovf4", v4, 0);
        check("reset busy4", busy4, 0);
        check("reset done4", done4, 0);
        check("reset sum8", sum8, 0);
        @(negedge clk);
        rst_n = 1;

        // Start in IDLE without a load must be ignored
        @(negedge clk);
        start4 = 1;
        repeat (3) @(negedge clk);
        check("idle start busy", busy4, 0);
        check("idle start done", done4, 0);
        start4 = 0;

        for (int i = 0; i < 9; i++)
            run4(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].s, vecs[i].c, vecs[i].v,
                 $sformatf("vec%0d", i));

        // Loaded but never started: nothing moves, previous result held
        begin
            int seen_busy = 0;
            int seen_done = 0;
            @(negedge clk);
            load4 = 1; a4 = 4'd6; b4 = 4'd2; mode4 = 0;
            @(negedge clk);
            load4 = 0;
            repeat (10) begin
                if (busy4) seen_busy++;
                if (done4) seen_done++;
                @(negedge clk);
            end
            check("no start busy", seen_busy, 0);
            check("no start done", seen_done, 0);
            check("no start sum held", sum4, 4'd7);
            check("no start carry held", c4, 1);

            // load and start together: load wins, stays LOADED
            load4 = 1; start4 = 1;
            @(negedge clk);
            load4 = 0; start4 = 0;
            seen_busy = 0;
            repeat (3) begin
                if (busy4) seen_busy++;
                @(negedge clk);
            end
            check("load+start ignored busy", seen_busy, 0);
            check("load+start ignored done", done4, 0);
        end
        // Still LOADED with 6+2: a plain start completes it
        begin
            int edges = 0;
            start4 = 1;
            @(negedge clk);
            start4 = 0;
            while (!done4 && edges < 20) begin
                @(negedge clk);
                edges++;
            end
            check("loaded start latency", edges, 4);
            check("loaded start sum", sum4, 4'd8);
            check("loaded start ovf", v4, 1);
        end

        // Asynchronous reset mid-RUN
        begin
            int seen = 0;
            @(negedge clk);
            load4 = 1; a4 = 4'd1; b4 = 4'd1; mode4 = 0;
            @(negedge clk);
            load4 = 0; start4 = 1;
            @(negedge clk);
            start4 = 0;
            @(posedge clk);
            @(posedge clk);
            #2;
            check("pre-reset busy", busy4, 1);
            rst_n = 0;
            #1;
            check("async reset sum", sum4, 0);
            check("async reset ovf", v4, 0);
            check("async reset busy", busy4, 0);
            check("async reset done", done4, 0);
            @(negedge clk);
            rst_n = 1;
            start4 = 1;
            repeat (10) begin
                if (done4 || busy4) seen++;
                @(negedge clk);
            end
            start4 = 0;
            check("no activity after reset", seen, 0);
            check("sum stays zero after reset", sum4, 0);
        end
        run4(4'd9, 4'd4, 1'b1, 4'd5, 1'b1, 1'b1, "post-reset");

        // 8-bit, 2-bit digits, start held high through and after done
        begin
            int edges = 0;
            int extra = 0;
            @(negedge clk);
            load8 = 1; a8 = 8'd200; b8 = 8'd100; mode8 = 0;
            @(negedge clk);
            load8 = 0; start8 = 1;
            @(negedge clk);
            while (!done8 && edges < 20) begin
                @(negedge clk);
                edges++;
            end
            check("w8 latency", edges, 4);
            check("w8 sum", sum8, 8'd44);
            check("w8 carry", c8, 1);
            check("w8 ovf", v8, 0);
            repeat (10) begin
                if (busy8 || !done8) extra++;
                @(negedge clk);
            end
            start8 = 0;
            check("w8 no retrigger", extra, 0);
            check("w8 sum held", sum8, 8'd44);

            // 10 - 20 in 8 bits
            load8 = 1; a8 = 8'd10; b8 = 8'd20; mode8 = 1;
            @(negedge clk);
            load8 = 0; start8 = 1;
            @(negedge clk);
            start8 = 0;
            edges = 0;
            while (!done8 && edges < 20) begin
                @(negedge clk);
                edges++;
            end
            check("w8 sub sum", sum8, 8'd246);
            check("w8 sub carry", c8, 0);
            check("w8 sub ovf", v8, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised digit-serial adder/subtractor; successor to the fixed 4-bit load/start/done serial adder.
- Adds configurable WIDTH and digit size (bits processed per cycle), a subtract mode, carry/borrow and signed-overflow flags, and a busy indicator.
- Operands are captured with load and processed LSB-digit first after start; the result is presented with a level done.
- Sits beside the existing serial adder as the general arithmetic engine for the exam datapath blocks.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).
- DIGIT, 1, bits processed per cycle; must divide WIDTH (elaboration-time assertion); NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  capture A, B, mode.
- start  in  1  begin operation on loaded operands.
- mode  in  1  0 = A+B, 1 = A-B.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- sum  out  WIDTH  result, registered.
- carry_out  out  1  add: carry out of MSB; sub: 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (level).

Behaviour:
- Reset (async, rst_n low): state IDLE; sum=0, carry_out=0, overflow=0, busy=0, done=0; shift registers, digit counter and carry cleared.
  - Takes effect mid-RUN immediately; the aborted operation yields nothing.
  - After release, operands must be reloaded.
- FSM states: IDLE, LOADED, RUN, DONE.
- load sampled high in IDLE, LOADED or DONE:
  - Capture A, B (inverted if mode=1), mode into registers.
  - Carry register <= mode.
  - done <= 0; go to LOADED.
  - sum, carry_out and overflow keep their previous values.
- load and start high in the same cycle: load wins, start ignored.
- load during RUN: ignored.
- start sampled high in LOADED: go to RUN, busy=1, digit counter=0.
- start in IDLE, RUN or DONE: ignored. A held-high start does not retrigger from DONE; a new load is required.
- RUN, each cycle:
  - One DIGIT-bit ripple add of the low digits of the A/B shift registers plus the carry register.
  - Result digit shifts into the result register from the MSB side.
  - Operand registers shift right by DIGIT; carry register updated; counter increments.
- Last digit (counter = NDIG-1):
  - Capture carry_out = carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Transfer the full result to sum; go to DONE; busy=0, done=1.
- Latency: done high NDIG rising edges after the edge that sampled start. WIDTH=4, DIGIT=1 gives 4 edges.
- sum, carry_out and overflow change only on the DONE transition or reset; stable from done until the next completion.
- DONE: hold until load; reset is the only other exit.
- All arithmetic is modulo 2^WIDTH; no saturation.
- Subtraction is A + ~B + 1 (the +1 via initial carry). A-0 gives carry_out=1; 0-1 gives sum=all ones, carry_out=0.

Decomposition:
- Package serial_arith_pkg:
  - State enum typedef (IDLE, LOADED, RUN, DONE).
  - Mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
  - Helper function for NDIG and the counter width, $clog2(NDIG) with minimum 1.
- One combinational sub-module, digit_adder:
  - Parameter DIGIT.
  - Inputs a, b, cin; outputs s, cout, and c_msb_in (carry into the digit's top bit) for overflow detection.
- Top holds the FSM, shift registers, counter and output registers.

Test Plan:
- WIDTH=4, DIGIT=1: load A=4, B=5, mode=0, then start -> done after exactly 4 edges; sum=9, carry_out=0, overflow=1, busy high exactly 4 cycles.
- WIDTH=4: A=4'b1100, B=4'b1011, add -> sum=4'b0111, carry_out=1, overflow=1. Then A=0, B=0 -> sum=0, carry_out=0, overflow=0.
- WIDTH=4, mode=1: A=3, B=5 -> sum=14, carry_out=0, overflow=0. A=5, B=3 -> sum=2, carry_out=1, overflow=0.
- Load A=6, B=2 with no start for 10 cycles -> done stays 0, busy stays 0, sum unchanged. Then load+start in the same cycle -> start ignored, state LOADED.
- Start, then pull rst_n low after 2 RUN cycles (asynchronously, mid-cycle) -> all outputs 0 immediately; no done after release until a new load/start.
- WIDTH=8, DIGIT=2: A=200, B=100, add -> done after 4 edges; sum=44, carry_out=1, overflow=0. Hold start high after done -> no retrigger; sum stays 44.
